// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Brief    : Shared constants, FSM encoding and helpers for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam int NUM_CORES  = 4;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_END  = 2'd3
    } arb_state_e;

    // Round-robin pointer advances to the core after the one just served.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Per-core request bundle plus the external multiplexed memory bus.
// Revision : 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int DATA_W = mem_bus_arbiter_pkg::DATA_W_DEF
);
    import mem_bus_arbiter_pkg::*;

    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        req_rnw;
    logic [NUM_CORES*DATA_W-1:0] req_addr;
    logic [NUM_CORES*DATA_W-1:0] req_wdata;
    logic [NUM_CORES-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [NUM_CORES-1:0]        grant;
    logic [DATA_W-1:0]           bus_dout;
    logic [DATA_W-1:0]           bus_din;
    logic                        bus_enb;
    logic                        nALE;
    logic                        nME;
    logic                        nOE;
    logic                        RnW;

    // Arbiter side: owns the external bus strobes and the completion signals.
    modport master (
        input  req, req_rnw, req_addr, req_wdata, bus_din,
        output ack, rdata, grant, bus_dout, bus_enb, nALE, nME, nOE, RnW
    );

    // Core / pad side.
    modport slave (
        output req, req_rnw, req_addr, req_wdata, bus_din,
        input  ack, rdata, grant, bus_dout, bus_enb, nALE, nME, nOE, RnW
    );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational 4-way round-robin picker (first request at/after ptr).
// Revision : 1.0
// ============================================================================
module rr_pick4 (
    input  wire logic [3:0] i_req,
    input  wire logic [1:0] i_ptr,
    output logic      [3:0] o_grant,
    output logic      [1:0] o_idx,
    output logic            o_any
);

    always_comb begin : b_pick
        logic [1:0] v_pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        v_pos   = '0;
        for (int i = 0; i < 4; i++) begin
            v_pos = i_ptr + 2'(i);
            if (!o_any && i_req[v_pos]) begin
                o_any          = 1'b1;
                o_idx          = v_pos;
                o_grant[v_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter sequencing four cores onto one muxed memory bus.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mem_bus_arbiter_if.master bus
);

    localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

    arb_state_e             r_state, w_state;
    logic [1:0]             r_ptr, w_ptr;
    logic [1:0]             r_idx, w_idx;
    logic                   r_rnw, w_rnw;
    logic [DATA_W-1:0]      r_wdata, w_wdata;
    logic [3:0]             r_wait, w_wait;
    logic [NUM_CORES-1:0]   r_grant, w_grant;
    logic [NUM_CORES-1:0]   r_ack, w_ack;
    logic [DATA_W-1:0]      r_rdata, w_rdata;
    logic [DATA_W-1:0]      r_bus_dout, w_bus_dout;
    logic                   r_bus_enb, w_bus_enb;
    logic                   r_nale, w_nale;
    logic                   r_nme, w_nme;
    logic                   r_noe, w_noe;
    logic                   r_rnw_out, w_rnw_out;

    logic [NUM_CORES-1:0]   w_pick_grant;
    logic [1:0]             w_pick_idx;
    logic                   w_pick_any;

    rr_pick4 u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Every output is computed for the state being entered, then registered.
    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_idx      = r_idx;
        w_rnw      = r_rnw;
        w_wdata    = r_wdata;
        w_wait     = r_wait;
        w_grant    = r_grant;
        w_ack      = '0;
        w_rdata    = r_rdata;
        w_bus_dout = r_bus_dout;
        w_bus_enb  = r_bus_enb;
        w_nale     = r_nale;
        w_nme      = r_nme;
        w_noe      = r_noe;
        w_rnw_out  = r_rnw_out;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state    = ST_ADDR;
                    w_grant    = w_pick_grant;
                    w_idx      = w_pick_idx;
                    w_rnw      = bus.req_rnw[w_pick_idx];
                    w_wdata    = bus.req_wdata[32'(w_pick_idx)*DATA_W +: DATA_W];
                    w_bus_dout = bus.req_addr[32'(w_pick_idx)*DATA_W +: DATA_W];
                    w_bus_enb  = 1'b0;
                    w_nale     = 1'b0;
                    w_nme      = 1'b1;
                    w_noe      = 1'b1;
                    w_rnw_out  = bus.req_rnw[w_pick_idx];
                end
            end
            ST_ADDR: begin
                w_state = ST_DATA;
                w_wait  = c_wait_init;
                w_nale  = 1'b0 | 1'b1;
                w_nme   = 1'b0;
                if (r_rnw) begin
                    w_bus_enb = 1'b1;
                    w_noe     = 1'b0;
                end else begin
                    w_bus_enb  = 1'b0;
                    w_bus_dout = r_wdata;
                    w_noe      = 1'b1;
                end
            end
            ST_DATA: begin
                if (r_wait == 4'd0) begin
                    w_state      = ST_END;
                    if (r_rnw) begin
                        w_rdata = bus.bus_din;
                    end
                    // Release the bus a full cycle before the next owner can drive it.
                    w_nme        = 1'b1;
                    w_noe        = 1'b1;
                    w_bus_enb    = 1'b1;
                    w_rnw_out    = 1'b1;
                    w_ack[r_idx] = 1'b1;
                    w_ptr        = next_ptr(r_idx);
                end else begin
                    w_wait = r_wait - 4'd1;
                end
            end
            ST_END: begin
                w_state = ST_IDLE;
                w_grant = '0;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_rnw      <= 1'b1;
            r_wdata    <= '0;
            r_wait     <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_bus_dout <= '0;
            r_bus_enb  <= 1'b1;
            r_nale     <= 1'b1;
            r_nme      <= 1'b1;
            r_noe      <= 1'b1;
            r_rnw_out  <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_idx      <= w_idx;
            r_rnw      <= w_rnw;
            r_wdata    <= w_wdata;
            r_wait     <= w_wait;
            r_grant    <= w_grant;
            r_ack      <= w_ack;
            r_rdata    <= w_rdata;
            r_bus_dout <= w_bus_dout;
            r_bus_enb  <= w_bus_enb;
            r_nale     <= w_nale;
            r_nme      <= w_nme;
            r_noe      <= w_noe;
            r_rnw_out  <= w_rnw_out;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.grant    = r_grant;
    assign bus.bus_dout = r_bus_dout;
    assign bus.bus_enb  = r_bus_enb;
    assign bus.nALE     = r_nale;
    assign bus.nME      = r_nme;
    assign bus.nOE      = r_noe;
    assign bus.RnW      = r_rnw_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed, table-driven self-checking bench for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_W(64)) if0 ();
    mem_bus_arbiter_if #(.DATA_W(64)) if2 ();

    mem_bus_arbiter #(.DATA_W(64), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mem_bus_arbiter #(.DATA_W(64), .WAIT_STATES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    typedef struct {
        logic [1:0]  core;
        logic        rnw;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] din;
        logic [3:0]  exp_ack;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input string nm, input logic enb, input logic noe, input logic nale,
                       input logic nme, input logic [3:0] ack, input logic [3:0] grant);
        checks++;
        if ((!enb && !noe) || !$onehot0(ack) || !$onehot0(grant) ||
            (!nale && (!nme || enb || grant == 4'b0))) begin
            errors++;
            $display("FAIL %s_invariant: enb=%b noe=%b nale=%b nme=%b ack=%b grant=%b",
                     nm, enb, noe, nale, nme, ack, grant);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon("dut0", if0.bus_enb, if0.nOE, if0.nALE, if0.nME, if0.ack, if0.grant);
            mon("dut2", if2.bus_enb, if2.nOE, if2.nALE, if2.nME, if2.ack, if2.grant);
        end
    end

    // Complete W=0 transfer on dut0, checked cycle by cycle.
    task automatic xfer0(input logic [1:0] core, input logic rnw, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] din,
                         input logic [3:0] exp_ack, input logic [63:0] exp_rdata);
        @(negedge clk);
        if0.req_rnw[core]                    = rnw;
        if0.req_addr[int'(core)*64 +: 64]    = addr;
        if0.req_wdata[int'(core)*64 +: 64]   = wdata;
        if0.bus_din                          = din;
        if0.req[core]                        = 1'b1;
        @(negedge clk);
        chk("addr_nale",  if0.nALE, 1'b0);
        chk("addr_dout",  if0.bus_dout, addr);
        chk("addr_rnw",   if0.RnW, rnw);
        chk("addr_enb",   if0.bus_enb, 1'b0);
        chk("addr_grant", if0.grant, exp_ack);
        @(negedge clk);
        chk("data_nme", if0.nME, 1'b0);
        chk("data_noe", if0.nOE, !rnw);
        chk("data_enb", if0.bus_enb, rnw);
        if (!rnw) chk("data_dout", if0.bus_dout, wdata);
        @(negedge clk);
        chk("end_ack",   if0.ack, exp_ack);
        chk("end_rdata", if0.rdata, exp_rdata);
        chk("end_nme",   if0.nME, 1'b1);
        chk("end_enb",   if0.bus_enb, 1'b1);
        if0.req[core] = 1'b0;
        @(negedge clk);
        chk("idle_ack",   if0.ack, 4'b0);
        chk("idle_grant", if0.grant, 4'b0);
    endtask

    task automatic wait_ack0(output logic [3:0] a);
        a = 4'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (if0.ack != 4'b0) begin
                a = if0.ack;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: got none expected an ack within 30 cycles");
    endtask

    initial begin
        logic [3:0] a;

        vecs[0] = '{2'd0, 1'b1, 64'h100, 64'h0,          64'hDEAD_BEEF, 4'b0001, 64'hDEAD_BEEF};
        vecs[1] = '{2'd1, 1'b0, 64'h300, 64'h1234_5678,  64'hBAD,       4'b0010, 64'hDEAD_BEEF};
        vecs[2] = '{2'd3, 1'b1, 64'h400, 64'h0,          64'hCAFE_F00D, 4'b1000, 64'hCAFE_F00D};
        vecs[3] = '{2'd2, 1'b1, 64'h500, 64'h0,          {64{1'b1}},    4'b0100, {64{1'b1}}};
        vecs[4] = '{2'd1, 1'b0, 64'h600, 64'hA5A5,       64'h0,         4'b0010, {64{1'b1}}};

        if0.req = '0; if0.req_rnw = '0; if0.req_addr = '0; if0.req_wdata = '0; if0.bus_din = '0;
        if2.req = '0; if2.req_rnw = '0; if2.req_addr = '0; if2.req_wdata = '0; if2.bus_din = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", if0.grant, 4'b0);
        chk("rst_ack",   if0.ack, 4'b0);
        chk("rst_rdata", if0.rdata, 64'h0);
        chk("rst_dout",  if0.bus_dout, 64'h0);
        chk("rst_strobes", {if0.bus_enb, if0.nALE, if0.nME, if0.nOE, if0.RnW}, 5'b11111);
        chk("rst2_strobes", {if2.bus_enb, if2.nALE, if2.nME, if2.nOE, if2.RnW}, 5'b11111);
        rst_n = 1'b1;

        // Table of single-core transfers on the W=0 instance
        for (int i = 0; i < 5; i++) begin
            xfer0(vecs[i].core, vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
                  vecs[i].din, vecs[i].exp_ack, vecs[i].exp_rdata);
        end

        // Core 2 write with two wait states
        @(negedge clk);
        if2.req_rnw[2]           = 1'b0;
        if2.req_addr[128 +: 64]  = 64'h200;
        if2.req_wdata[128 +: 64] = 64'h55AA;
        if2.bus_din              = 64'h1111;
        if2.req[2]               = 1'b1;
        @(negedge clk);
        chk("w2_addr_nale", if2.nALE, 1'b0);
        chk("w2_addr_dout", if2.bus_dout, 64'h200);
        chk("w2_addr_rnw",  if2.RnW, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w2_data_enb",  if2.bus_enb, 1'b0);
            chk("w2_data_dout", if2.bus_dout, 64'h55AA);
            chk("w2_data_noe",  if2.nOE, 1'b1);
            chk("w2_data_nme",  if2.nME, 1'b0);
            chk("w2_data_rnw",  if2.RnW, 1'b0);
            chk("w2_data_ack",  if2.ack, 4'b0);
        end
        @(negedge clk);
        chk("w2_end_ack",   if2.ack, 4'b0100);
        chk("w2_end_rdata", if2.rdata, 64'h0);
        if2.req[2] = 1'b0;
        @(negedge clk);
        chk("w2_idle_ack", if2.ack, 4'b0);

        // All four cores requesting continuously from reset
        rst_n = 1'b0;
        if0.req_rnw = 4'b1111;
        if0.req     = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ack0(a);
            chk("rr_order_ack",   a, 4'b0001 << (k % 4));
            chk("rr_order_grant", if0.grant, 4'b0001 << (k % 4));
        end
        if0.req = 4'b0;

        // Pointer at 1, cores 0 and 3 requesting: core 3 wins first
        xfer0(2'd0, 1'b1, 64'h700, 64'h0, 64'h77, 4'b0001, 64'h77);
        @(negedge clk);
        if0.req = 4'b1001;
        wait_ack0(a);
        chk("ptr1_first",  a, 4'b1000);
        if0.req[3] = 1'b0;
        wait_ack0(a);
        chk("ptr1_second", a, 4'b0001);
        if0.req[0] = 1'b0;

        // Reset during DATA, then pending requests restart from ptr 0
        xfer0(2'd2, 1'b1, 64'h800, 64'h0, 64'h88, 4'b0100, 64'h88);
        @(negedge clk);
        if0.req_rnw[1] = 1'b1;
        if0.req[1]     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_nme", if0.nME, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {if0.bus_enb, if0.nALE, if0.nME, if0.nOE, if0.RnW}, 5'b11111);
        chk("rst_mid_grant", if0.grant, 4'b0);
        chk("rst_mid_ack",   if0.ack, 4'b0);
        if0.req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack0(a);
        chk("rst_restart_first", a, 4'b0010);
        if0.req[1] = 1'b0;
        wait_ack0(a);
        chk("rst_restart_second", a, 4'b1000);
        if0.req[3] = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
